clock_config_controller: RTL and testbench

CLOCK_CONFIG_CONTROLLER -- requirements
Module: clock_config_controller

---
 rtl/clock_config_pkg.sv | 30 +++
 rtl/clock_config_regfile.sv | 99 +++++++++
 rtl/clock_config_controller.sv | 109 ++++++++++
 tb/tb_clock_config_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_config_pkg.sv
// Shared definitions for the clock configuration controller:
// register word offsets, change-FSM states and divisor helpers.
package clock_config_pkg;

  localparam logic [4:0] DEFAULT_DIVISOR = 5'd10;

  localparam logic [3:0] REG_DIVISOR  = 4'h0;
  localparam logic [3:0] REG_STATUS   = 4'h1;
  localparam logic [3:0] REG_TICKS_LO = 4'h2;
  localparam logic [3:0] REG_TICKS_HI = 4'h3;
  localparam logic [3:0] REG_MS_LO    = 4'h4;
  localparam logic [3:0] REG_MS_HI    = 4'h5;
  localparam logic [3:0] REG_CMP_LO   = 4'h6;
  localparam logic [3:0] REG_CMP_HI   = 4'h7;
  localparam logic [3:0] REG_IRQ      = 4'h8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STALL,
    ST_DRAIN,
    ST_APPLY,
    ST_RELEASE
  } state_t;

  // A divide-by-zero request is meaningless; treat it as divide-by-one.
  function automatic logic [4:0] clamp_divisor(input logic [31:0] d);
    return (d[4:0] == 5'd0) ? 5'd1 : d[4:0];
  endfunction

endpackage

// File: rtl/clock_config_regfile.sv
// Bus decode, counter shadows, compare and interrupt registers.
// Divisor writes are handed to the change FSM in the top level.
module clock_config_regfile
  import clock_config_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  bus_address,
  input  logic        bus_write_enable,
  input  logic        bus_read_enable,
  input  logic [31:0] bus_write_data,
  output logic [31:0] bus_read_data,
  output logic        bus_ready,
  input  logic [63:0] core_clock_ticks,
  input  logic [63:0] miliseconds,
  input  logic [4:0]  divisor,
  input  logic        busy,
  input  logic        pending,
  output logic        divisor_write,
  output logic [4:0]  divisor_data,
  output logic        timer_interrupt
);

  logic [3:0]  word;
  logic        wr;
  logic        rd;
  logic [31:0] rdata;
  logic [31:0] ticks_shadow;
  logic [31:0] ms_shadow;
  logic [31:0] cmp_lo;
  logic [31:0] cmp_hi;
  logic        irq_en;
  logic        irq_pend;
  logic        irq_set;
  logic        irq_clr;
  logic        en_next;
  logic        pend_next;
  logic        unused_addr;

  assign word        = bus_address[5:2];
  assign unused_addr = ^bus_address[1:0];
  assign wr          = bus_write_enable;
  assign rd          = bus_read_enable & ~bus_write_enable;

  assign divisor_write = wr && (word == REG_DIVISOR);
  assign divisor_data  = clamp_divisor(bus_write_data);

  assign irq_set   = miliseconds >= {cmp_hi, cmp_lo};
  assign irq_clr   = wr && (word == REG_IRQ) && bus_write_data[1];
  assign en_next   = (wr && (word == REG_IRQ)) ? bus_write_data[0] : irq_en;
  assign pend_next = irq_set | (irq_pend & ~irq_clr);

  always_comb begin
    rdata = 32'd0;
    if (rd) begin
      unique case (1'b1)
        (word == REG_DIVISOR):  rdata = {27'd0, divisor};
        (word == REG_STATUS):   rdata = {30'd0, pending, busy};
        (word == REG_TICKS_LO): rdata = core_clock_ticks[31:0];
        (word == REG_TICKS_HI): rdata = ticks_shadow;
        (word == REG_MS_LO):    rdata = miliseconds[31:0];
        (word == REG_MS_HI):    rdata = ms_shadow;
        (word == REG_CMP_LO):   rdata = cmp_lo;
        (word == REG_CMP_HI):   rdata = cmp_hi;
        (word == REG_IRQ):      rdata = {30'd0, irq_pend, irq_en};
        default:                rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_ready       <= 1'b0;
      bus_read_data   <= 32'd0;
      ticks_shadow    <= 32'd0;
      ms_shadow       <= 32'd0;
      cmp_lo          <= '1;
      cmp_hi          <= '1;
      irq_en          <= 1'b0;
      irq_pend        <= 1'b0;
      timer_interrupt <= 1'b0;
    end else begin
      bus_ready     <= bus_write_enable | bus_read_enable;
      bus_read_data <= rdata;
      if (rd && (word == REG_TICKS_LO))
        ticks_shadow <= core_clock_ticks[63:32];
      if (rd && (word == REG_MS_LO))
        ms_shadow <= miliseconds[63:32];
      if (wr && (word == REG_CMP_LO))
        cmp_lo <= bus_write_data;
      if (wr && (word == REG_CMP_HI))
        cmp_hi <= bus_write_data;
      irq_en          <= en_next;
      irq_pend        <= pend_next;
      timer_interrupt <= en_next & pend_next;
    end
  end

endmodule

// File: rtl/clock_config_controller.sv
// Clock configuration block: register file plus the divisor change
// sequencer that stalls the core around every divisor update.
module clock_config_controller #(
  parameter logic [4:0] DEFAULT_DIVISOR = clock_config_pkg::DEFAULT_DIVISOR,
  parameter int         DRAIN_TICKS     = 2
) (
  input  logic        clock_100mhz,
  input  logic        reset,
  input  logic [5:0]  bus_address,
  input  logic        bus_write_enable,
  input  logic        bus_read_enable,
  input  logic [31:0] bus_write_data,
  output logic [31:0] bus_read_data,
  output logic        bus_ready,
  input  logic        divider_tick,
  input  logic [63:0] core_clock_ticks,
  input  logic [63:0] miliseconds,
  output logic [4:0]  core_clock_divisor,
  output logic        stall_request,
  output logic        timer_interrupt
);
  import clock_config_pkg::*;

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TICKS - 1);

  state_t     state;
  logic [4:0] pending_divisor;
  logic       pending;
  logic [7:0] drain_cnt;
  logic       div_wr;
  logic [4:0] div_data;

  clock_config_regfile u_regfile (
    .clk              (clock_100mhz),
    .reset            (reset),
    .bus_address      (bus_address),
    .bus_write_enable (bus_write_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_write_data   (bus_write_data),
    .bus_read_data    (bus_read_data),
    .bus_ready        (bus_ready),
    .core_clock_ticks (core_clock_ticks),
    .miliseconds      (miliseconds),
    .divisor          (core_clock_divisor),
    .busy             (state != ST_IDLE),
    .pending          (pending),
    .divisor_write    (div_wr),
    .divisor_data     (div_data),
    .timer_interrupt  (timer_interrupt)
  );

  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      state              <= ST_IDLE;
      core_clock_divisor <= DEFAULT_DIVISOR;
      pending_divisor    <= DEFAULT_DIVISOR;
      pending            <= 1'b0;
      drain_cnt          <= 8'd0;
      stall_request      <= 1'b0;
    end else begin
      // Any write just records the latest request; the FSM picks it up.
      if (div_wr) begin
        pending_divisor <= div_data;
        pending         <= 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (div_wr) begin
            state         <= ST_STALL;
            stall_request <= 1'b1;
          end
        end
        ST_STALL: begin
          drain_cnt <= 8'd0;
          state     <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (divider_tick) begin
            if (drain_cnt == DRAIN_LAST)
              state <= ST_APPLY;
            else
              drain_cnt <= drain_cnt + 8'd1;
          end
        end
        ST_APPLY: begin
          core_clock_divisor <= pending_divisor;
          if (!div_wr)
            pending <= 1'b0;
          state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (divider_tick) begin
            if (pending || div_wr) begin
              state <= ST_STALL;
            end else begin
              state         <= ST_IDLE;
              stall_request <= 1'b0;
            end
          end
        end
        default: begin
          state         <= ST_IDLE;
          stall_request <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_config_controller.sv
// Directed bench for clock_config_controller with a per-cycle model
// of bus handshake and interrupt behaviour.
module tb_clock_config_controller;

  localparam logic [5:0] A_DIV  = 6'h00;
  localparam logic [5:0] A_STAT = 6'h04;
  localparam logic [5:0] A_TLO  = 6'h08;
  localparam logic [5:0] A_THI  = 6'h0C;
  localparam logic [5:0] A_MLO  = 6'h10;
  localparam logic [5:0] A_MHI  = 6'h14;
  localparam logic [5:0] A_CLO  = 6'h18;
  localparam logic [5:0] A_CHI  = 6'h1C;
  localparam logic [5:0] A_IRQ  = 6'h20;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        tick;
  logic [63:0] ticks;
  logic [63:0] ms;
  logic [4:0]  div;
  logic        stall;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int div_changes = 0;
  bit started = 0;

  always #5 clk = ~clk;

  clock_config_controller #(.DEFAULT_DIVISOR(5'd10), .DRAIN_TICKS(2)) dut (
    .clock_100mhz       (clk),
    .reset              (reset),
    .bus_address        (addr),
    .bus_write_enable   (we),
    .bus_read_enable    (re),
    .bus_write_data     (wdata),
    .bus_read_data      (rdata),
    .bus_ready          (ready),
    .divider_tick       (tick),
    .core_clock_ticks   (ticks),
    .miliseconds        (ms),
    .core_clock_divisor (div),
    .stall_request      (stall),
    .timer_interrupt    (irq)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: handshake and interrupt rules evaluated from the inputs only.
  logic        m_ready;
  logic        m_en;
  logic        m_pend;
  logic        m_irq;
  logic [63:0] m_cmp;
  logic        m_rst;

  always @(posedge clk) begin
    m_rst = reset;
    if (reset) begin
      m_ready = 0;
      m_en    = 0;
      m_pend  = 0;
      m_irq   = 0;
      m_cmp   = '1;
    end else begin
      m_ready = we | re;
      if (we && addr[5:2] == 4'h8)
        m_en = wdata[0];
      if (ms >= m_cmp)
        m_pend = 1;
      else if (we && addr[5:2] == 4'h8 && wdata[1])
        m_pend = 0;
      m_irq = m_en & m_pend;
      if (we && addr[5:2] == 4'h6) m_cmp[31:0]  = wdata;
      if (we && addr[5:2] == 4'h7) m_cmp[63:32] = wdata;
    end
  end

  logic [4:0] prev_div;

  always @(negedge clk) begin
    if (started) begin
      chk("bus_ready", ready, m_ready);
      chk("timer_interrupt", irq, m_irq);
      if (!m_rst && div !== prev_div) begin
        chk("div_change_under_stall", stall, 1);
        div_changes++;
      end
    end
    prev_div = div;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1;
    @(negedge clk);
    we = 0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp,
                    input string nm);
    addr = a; re = 1;
    @(negedge clk);
    re = 0;
    chk(nm, rdata, exp);
  endtask

  task automatic pulse;
    tick = 1;
    @(negedge clk);
    tick = 0;
  endtask

  task automatic drain_pass;
    pulse(); idle(1); pulse(); idle(1); pulse();
  endtask

  int base;

  initial begin
    reset = 1; addr = 0; we = 0; re = 0; wdata = 0; tick = 0;
    ticks = 0; ms = 0;
    idle(2);
    reset = 0;
    started = 1;
    idle(1);

    // Reset state
    chk("rst_stall", stall, 0);
    chk("rst_irq", irq, 0);
    chk("rst_div", div, 10);
    rd(A_DIV, 10, "rd_div_reset");
    rd(A_STAT, 0, "rd_status_reset");
    rd(A_THI, 0, "rd_ticks_shadow_reset");
    rd(A_CHI, 32'hFFFFFFFF, "rd_cmp_hi_reset");

    // Single change to 4
    wr(A_DIV, 4);
    chk("w4_stall_next", stall, 1);
    chk("w4_div_old", div, 10);
    rd(A_STAT, 3, "rd_status_busy");
    pulse();
    chk("w4_div_after_t1", div, 10);
    idle(1);
    pulse();
    chk("w4_div_apply_state", div, 10);
    idle(1);
    chk("w4_div_applied", div, 4);
    chk("w4_stall_release", stall, 1);
    pulse();
    chk("w4_stall_low", stall, 0);
    rd(A_DIV, 4, "rd_div_4");
    rd(A_STAT, 0, "rd_status_idle");

    // 4 then 7 during DRAIN: only 7 is applied
    base = div_changes;
    wr(A_DIV, 4);
    idle(1);
    wr(A_DIV, 7);
    drain_pass();
    chk("w7_div", div, 7);
    chk("w7_stall", stall, 0);
    chk("w7_single_change", div_changes - base, 1);

    // Zero (upper bits set) stores as 1
    wr(A_DIV, 32'hFFFF_FFE0);
    idle(1);
    drain_pass();
    rd(A_DIV, 1, "rd_div_zero_as_1");

    // Write during RELEASE re-enters STALL
    wr(A_DIV, 4);
    idle(1); pulse(); idle(1); pulse(); idle(1);
    chk("w9_div_first", div, 4);
    wr(A_DIV, 9);
    chk("w9_stall_release", stall, 1);
    pulse();
    chk("w9_stall_no_gap", stall, 1);
    rd(A_STAT, 3, "rd_status_repass");
    drain_pass();
    chk("w9_div_final", div, 9);
    chk("w9_stall_low", stall, 0);

    // Counter shadows
    ticks = 64'h1_FFFF_FFFF;
    rd(A_TLO, 32'hFFFFFFFF, "rd_ticks_lo");
    ticks = 64'h2_0000_0000;
    rd(A_THI, 1, "rd_ticks_hi_shadow");
    ms = 64'h0000_0003_0000_0000;
    rd(A_MLO, 0, "rd_ms_lo");
    ms = 64'h0000_0004_1234_0000;
    rd(A_MHI, 3, "rd_ms_hi_shadow");
    ms = 0;

    // Read+write together acts as a write; unmapped accesses
    addr = A_CLO; wdata = 32'h55; we = 1; re = 1;
    @(negedge clk);
    we = 0; re = 0;
    chk("rdwr_data_zero", rdata, 0);
    rd(A_CLO, 32'h55, "rd_cmp_lo_written");
    rd(6'h24, 0, "rd_unmapped_24");
    wr(6'h3C, 32'hDEAD);
    rd(6'h3C, 0, "rd_unmapped_3c");

    // Compare interrupt
    wr(A_CLO, 5);
    wr(A_CHI, 0);
    wr(A_IRQ, 1);
    ms = 4;
    idle(2);
    chk("irq_below_cmp", irq, 0);
    ms = 5;
    idle(1);
    chk("irq_at_cmp", irq, 1);
    wr(A_IRQ, 3);
    chk("irq_clear_vs_set", irq, 1);
    rd(A_IRQ, 3, "rd_irq_pend_en");
    ms = 4;
    wr(A_IRQ, 3);
    chk("irq_cleared", irq, 0);
    rd(A_IRQ, 1, "rd_irq_en_only");

    // Reset in the middle of a change
    wr(A_DIV, 3);
    idle(1);
    pulse();
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("mid_rst_div", div, 10);
    chk("mid_rst_stall", stall, 0);
    rd(A_STAT, 0, "rd_status_after_rst");
    rd(A_DIV, 10, "rd_div_after_rst");
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
